imem_responder: RTL and testbench

Instruction-memory responder: the slave end of the fetch stage's instruction-memory port. Holds the program in a word-addressed array and returns the instruction word for the fetch address in the same cycle. A byte-serial program-load port fills the array, and the core is held off fetching while a load is in progress. Sits between the fetch stage and the board-level boot/debug loader.

---
 rtl/imem_responder_pkg.sv | 13 +
 rtl/imem_if.sv | 33 +++
 rtl/imem_byte_packer.sv | 36 +++
 rtl/imem_responder.sv | 100 ++++++++++
 tb/tb_imem_responder.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/imem_responder_pkg.sv
// Shared types and constants for the instruction-memory responder.
package imem_responder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } imem_state_t;

    localparam logic [31:0] DEF_START_ADDR = 32'h0;
    localparam logic [31:0] NOP_WORD       = 32'h0;

endpackage

// File: rtl/imem_if.sv
// Fetch port plus byte-serial program-load port of the instruction memory.
interface imem_if #(
    parameter int AW = 10
);

    logic [31:0]   i_IMEM_addr;
    logic [31:0]   o_IMEM_dataR;
    logic          o_IMEM_hold;
    logic          i_IMEM_run;
    logic          i_LD_start;
    logic [AW-1:0] i_LD_base;
    logic [AW:0]   i_LD_len;
    logic          i_LD_valid;
    logic [7:0]    i_LD_byte;
    logic          o_LD_ready;
    logic          o_LD_busy;
    logic          o_IMEM_err;

    modport slave (
        input  i_IMEM_addr, i_IMEM_run, i_LD_start,
        input  i_LD_base, i_LD_len, i_LD_valid, i_LD_byte,
        output o_IMEM_dataR, o_IMEM_hold, o_LD_ready,
        output o_LD_busy, o_IMEM_err
    );

    modport master (
        output i_IMEM_addr, i_IMEM_run, i_LD_start,
        output i_LD_base, i_LD_len, i_LD_valid, i_LD_byte,
        input  o_IMEM_dataR, o_IMEM_hold, o_LD_ready,
        input  o_LD_busy, o_IMEM_err
    );

endinterface

// File: rtl/imem_byte_packer.sv
// Assembles little-endian bytes into 32-bit words; strobes on the 4th byte.
module imem_byte_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        accept,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        word_valid
);

    logic [1:0]  byte_cnt;
    logic [23:0] shreg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_cnt <= 2'd0;
            shreg    <= 24'h0;
        end else if (clr) begin
            byte_cnt <= 2'd0;
        end else if (accept) begin
            byte_cnt <= byte_cnt + 2'd1;
            unique case (byte_cnt)
                2'd0:    shreg[7:0]   <= byte_in;
                2'd1:    shreg[15:8]  <= byte_in;
                2'd2:    shreg[23:16] <= byte_in;
                default: ;
            endcase
        end
    end

    // The top byte bypasses the register so the word commits on its own edge.
    assign word       = {byte_in, shreg};
    assign word_valid = accept && (byte_cnt == 2'd3);

endmodule

// File: rtl/imem_responder.sv
// Word-addressed instruction memory with async read and a byte-serial loader.
module imem_responder
    import imem_responder_pkg::*;
#(
    parameter logic [31:0] MIPS_START_ADDR = DEF_START_ADDR,
    parameter int          DEPTH_WORDS     = 1024
) (
    input  logic   clk,
    input  logic   rst,
    imem_if.slave  bus
);

    localparam int AW = $clog2(DEPTH_WORDS);

    imem_state_t state, state_nx;

    logic [31:0]   mem [DEPTH_WORDS];
    logic [AW-1:0] wptr;
    logic [AW:0]   remaining;
    logic          err;
    logic          start_load;
    logic          accept;
    logic [31:0]   word;
    logic          word_valid;
    logic [31:0]   offset;
    logic          rd_ok;
    logic          last_word;

    assign start_load = bus.i_LD_start && (state != LOAD);
    assign accept     = bus.i_LD_valid && bus.o_LD_ready;
    assign last_word  = word_valid && (remaining == {{AW{1'b0}}, 1'b1});

    imem_byte_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .clr        (start_load),
        .accept     (accept),
        .byte_in    (bus.i_LD_byte),
        .word       (word),
        .word_valid (word_valid)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (bus.i_LD_start)     state_nx = LOAD;
                else if (bus.i_IMEM_run) state_nx = RUN;
            end
            LOAD: begin
                if (remaining == '0 || last_word) state_nx = RUN;
            end
            RUN: begin
                if (bus.i_LD_start) state_nx = LOAD;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        bus.o_IMEM_hold = (state != RUN);
        bus.o_LD_busy   = (state == LOAD);
        bus.o_LD_ready  = (state == LOAD) && (remaining != '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr      <= '0;
            remaining <= '0;
            err       <= 1'b0;
        end else if (start_load) begin
            wptr      <= bus.i_LD_base;
            remaining <= bus.i_LD_len;
            err       <= 1'b0;
        end else begin
            if (word_valid) begin
                wptr      <= wptr + 1'b1;
                remaining <= remaining - 1'b1;
            end
            if (state == RUN && !rd_ok) err <= 1'b1;
        end
    end

    // Contents survive reset so a core reset does not need a reload.
    always_ff @(posedge clk) begin
        if (word_valid) mem[wptr] <= word;
    end

    assign offset = bus.i_IMEM_addr - MIPS_START_ADDR;
    assign rd_ok  = (offset[1:0] == 2'b00) && (offset[31:AW+2] == '0);

    assign bus.o_IMEM_dataR = rd_ok ? mem[offset[AW+1:2]] : NOP_WORD;
    assign bus.o_IMEM_err   = err;

endmodule

// File: tb/tb_imem_responder.sv
// Directed scoreboard bench for imem_responder.
module tb_imem_responder;

    localparam int DEPTH = 1024;
    localparam int AW    = 10;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } sb_t;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    imem_if #(.AW(AW)) bus ();

    imem_responder #(
        .MIPS_START_ADDR (32'h0),
        .DEPTH_WORDS     (DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    sb_t sb_q[$];
    int  vectors     = 0;
    int  miscompares = 0;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_status(input string tag,
                                input logic hold, input logic ready,
                                input logic busy, input logic err);
        chk({tag, ".hold"},  {31'h0, bus.o_IMEM_hold}, {31'h0, hold});
        chk({tag, ".ready"}, {31'h0, bus.o_LD_ready},  {31'h0, ready});
        chk({tag, ".busy"},  {31'h0, bus.o_LD_busy},   {31'h0, busy});
        chk({tag, ".err"},   {31'h0, bus.o_IMEM_err},  {31'h0, err});
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.i_LD_valid = 1'b1;
        bus.i_LD_byte  = b;
        tick();
        bus.i_LD_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
    endtask

    task automatic start_load(input logic [AW-1:0] base,
                              input logic [AW:0] len);
        bus.i_LD_start = 1'b1;
        bus.i_LD_base  = base;
        bus.i_LD_len   = len;
        tick();
        bus.i_LD_start = 1'b0;
        bus.i_IMEM_run = 1'b0;
    endtask

    task automatic expect_word(input logic [31:0] a, input logic [31:0] d);
        sb_q.push_back({a, d});
    endtask

    task automatic drain();
        sb_t e;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            bus.i_IMEM_addr = e.addr;
            #1;
            chk($sformatf("read@%h", e.addr), bus.o_IMEM_dataR, e.data);
        end
    endtask

    initial begin
        rst            = 1'b1;
        bus.i_IMEM_addr = 32'h0;
        bus.i_IMEM_run = 1'b0;
        bus.i_LD_start = 1'b0;
        bus.i_LD_base  = '0;
        bus.i_LD_len   = '0;
        bus.i_LD_valid = 1'b0;
        bus.i_LD_byte  = 8'h0;

        // reset release, then run
        repeat (2) @(posedge clk);
        #1;
        check_status("reset", 1'b1, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        #1;
        check_status("rst_rel", 1'b1, 1'b0, 1'b0, 1'b0);
        bus.i_IMEM_run = 1'b1;
        tick();
        bus.i_IMEM_run = 1'b0;
        #1;
        check_status("run", 1'b0, 1'b0, 1'b0, 1'b0);

        // basic two-word load
        start_load(10'd0, 11'd2);
        #1;
        check_status("ld_start", 1'b1, 1'b1, 1'b1, 1'b0);
        send_word(32'h2008_0001);
        send_byte(8'hFF);
        send_byte(8'hFF);
        send_byte(8'h00);
        #1;
        check_status("pre_last", 1'b1, 1'b1, 1'b1, 1'b0);
        send_byte(8'h10);
        #1;
        check_status("ld_done", 1'b0, 1'b0, 1'b0, 1'b0);
        expect_word(32'h0, 32'h2008_0001);
        expect_word(32'h4, 32'h1000_FFFF);
        drain();

        // wrap from the last index to 0, with write-then-read on word 0
        start_load(10'd1023, 11'd2);
        send_word(32'hA1A2_A3A4);
        send_byte(8'hB4);
        send_byte(8'hB3);
        send_byte(8'hB2);
        bus.i_IMEM_addr = 32'h0;
        bus.i_LD_valid  = 1'b1;
        bus.i_LD_byte   = 8'hB1;
        #1;
        chk("commit_old", bus.o_IMEM_dataR, 32'h2008_0001);
        tick();
        bus.i_LD_valid = 1'b0;
        #1;
        chk("commit_new", bus.o_IMEM_dataR, 32'hB1B2_B3B4);
        check_status("wrap_done", 1'b0, 1'b0, 1'b0, 1'b0);
        expect_word(32'd4092, 32'hA1A2_A3A4);
        expect_word(32'h0, 32'hB1B2_B3B4);
        expect_word(32'h4, 32'h1000_FFFF);
        drain();

        // misaligned and out-of-range fetches
        bus.i_IMEM_addr = 32'h2;
        #1;
        chk("misal.data", bus.o_IMEM_dataR, 32'h0);
        chk("misal.err0", {31'h0, bus.o_IMEM_err}, 32'h0);
        tick();
        chk("misal.err1", {31'h0, bus.o_IMEM_err}, 32'h1);
        bus.i_IMEM_addr = 32'd4096;
        #1;
        chk("oor.data", bus.o_IMEM_dataR, 32'h0);
        bus.i_IMEM_addr = 32'hFFFF_FFFC;
        #1;
        chk("oor_hi.data", bus.o_IMEM_dataR, 32'h0);
        bus.i_IMEM_addr = 32'h4;
        tick();
        chk("valid.data", bus.o_IMEM_dataR, 32'h1000_FFFF);
        chk("err_sticky", {31'h0, bus.o_IMEM_err}, 32'h1);

        // zero-length load clears err and spends one LOAD cycle
        bus.i_IMEM_addr = 32'h0;
        start_load(10'd7, 11'd0);
        #1;
        check_status("len0", 1'b1, 1'b0, 1'b1, 1'b0);
        tick();
        check_status("len0_run", 1'b0, 1'b0, 1'b0, 1'b0);

        // start and run together from IDLE; start during LOAD ignored
        rst = 1'b1;
        #2;
        rst = 1'b0;
        #1;
        check_status("rst2", 1'b1, 1'b0, 1'b0, 1'b0);
        bus.i_IMEM_run = 1'b1;
        start_load(10'd5, 11'd1);
        #1;
        check_status("both", 1'b1, 1'b1, 1'b1, 1'b0);
        start_load(10'd9, 11'd3);
        send_byte(8'h44);
        send_byte(8'h33);
        send_byte(8'h22);
        send_byte(8'h11);
        #1;
        check_status("ign_start", 1'b0, 1'b0, 1'b0, 1'b0);
        send_byte(8'hEE);
        expect_word(32'h14, 32'h1122_3344);
        expect_word(32'h0, 32'hB1B2_B3B4);
        expect_word(32'h4, 32'h1000_FFFF);
        drain();

        // reset in the middle of word 1
        start_load(10'd0, 11'd2);
        send_word(32'hC3C2_C1C0);
        send_byte(8'hD0);
        send_byte(8'hD1);
        #1;
        rst = 1'b1;
        #1;
        check_status("midrst", 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        rst = 1'b0;
        bus.i_IMEM_addr = 32'h4;
        #1;
        chk("partial_drop", bus.o_IMEM_dataR, 32'h1000_FFFF);
        start_load(10'd1, 11'd1);
        send_word(32'hE3E2_E1E0);
        #1;
        check_status("reload", 1'b0, 1'b0, 1'b0, 1'b0);
        expect_word(32'h0, 32'hC3C2_C1C0);
        expect_word(32'h4, 32'hE3E2_E1E0);
        expect_word(32'h14, 32'h1122_3344);
        expect_word(32'd4092, 32'hA1A2_A3A4);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
